// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if: request/grant, flit and credit signals of one router output arbiter.
// master drives the input-port side; slave is the arbiter.
interface noc_output_arbiter_if #(
   parameter int NUM_IN = 5,
   parameter int FLIT_W = 64
);
   logic [NUM_IN-1:0]        req;
   logic [NUM_IN-1:0]        pw;
   logic [NUM_IN*FLIT_W-1:0] flit_in;
   logic                     credit_ret;
   logic [NUM_IN-1:0]        gnt;
   logic [FLIT_W-1:0]        flit_out;
   logic                     valid_out;
   logic [2:0]               credits;
   logic                     locked;
   logic [2:0]               owner;
   logic                     credit_err;
   modport master (
      output req, pw, flit_in, credit_ret,
      input  gnt, flit_out, valid_out, credits, locked, owner, credit_err
   );
   modport slave (
      input  req, pw, flit_in, credit_ret,
      output gnt, flit_out, valid_out, credits, locked, owner, credit_err
   );
endinterface

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin wormhole arbiter with credit metering for one router output.
// Define ARB_PW_PRIORITY_EN to let pw-flagged inputs win arbitration ahead of the rest.
module noc_output_arbiter #(
   parameter int NUM_IN  = 5,
   parameter int FLIT_W  = 64,
   parameter int CREDITS = 4
) (
   input logic                 clk_i,
   input logic                 rst_i,
   noc_output_arbiter_if.slave bus_io
);
   typedef enum logic {IDLE, LOCKED} state_e;
   state_e            state_q, state_d;
   logic [2:0]        owner_q, owner_d, rr_q, rr_d, cred_q, cred_d, win;
   logic [FLIT_W-1:0] flit_q, own_flit;
   logic              valid_q, err_q, err_d, grant;
   logic [NUM_IN-1:0] elig, cand;
   // heads and single-flit packets have equal type bits
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_IN; i++)
         elig[i] = bus_io.req[i] && cred_q != 3'd0 &&
                   bus_io.flit_in[i*FLIT_W+FLIT_W-1] == bus_io.flit_in[i*FLIT_W+FLIT_W-2];
   end
`ifdef ARB_PW_PRIORITY_EN
   assign cand = |(elig & bus_io.pw) ? elig & bus_io.pw : elig;
`else
   logic unused_pw;
   assign unused_pw = ^bus_io.pw;
   assign cand = elig;
`endif
   // descending scan so the first candidate at or after rr_q is the last written
   always_comb begin
      win = '0;
      for (int k = NUM_IN - 1; k >= 0; k--)
         if (cand[(int'(rr_q) + k) % NUM_IN]) win = 3'((int'(rr_q) + k) % NUM_IN);
   end
   assign own_flit = bus_io.flit_in[owner_q*FLIT_W +: FLIT_W];
   assign grant    = state_q == LOCKED && bus_io.req[owner_q] && cred_q != 3'd0;
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      if (state_q == IDLE && |cand) begin
         state_d = LOCKED;
         owner_d = win;
      end
      if (grant && !own_flit[FLIT_W-2]) begin
         state_d = IDLE;
         rr_d    = owner_q == 3'(NUM_IN - 1) ? 3'd0 : owner_q + 3'd1;
      end
      cred_d = grant && !bus_io.credit_ret ? cred_q - 3'd1 :
               !grant && bus_io.credit_ret && cred_q != 3'(CREDITS) ? cred_q + 3'd1 : cred_q;
      err_d  = err_q || (bus_io.credit_ret && !grant && cred_q == 3'(CREDITS));
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         cred_q  <= 3'(CREDITS);
         flit_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cred_q  <= cred_d;
         flit_q  <= grant ? own_flit : flit_q;
         valid_q <= grant;
         err_q   <= err_d;
      end
   end
   assign bus_io.gnt        = grant ? NUM_IN'(1) << owner_q : '0;
   assign bus_io.flit_out   = flit_q;
   assign bus_io.valid_out  = valid_q;
   assign bus_io.credits    = cred_q;
   assign bus_io.locked     = state_q == LOCKED;
   assign bus_io.owner      = owner_q;
   assign bus_io.credit_err = err_q;
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: per-cycle vector table plus flit scoreboard for noc_output_arbiter.
// Flit payload = {type, cycle, input} so every granted flit is traceable on flit_out.
module tb_noc_output_arbiter;
   typedef struct {
      logic [4:0] req;
      logic [9:0] typ;
      logic       cr;
      logic [4:0] eg;
      logic       el;
      logic [2:0] ec;
      logic       ev;
      logic [2:0] eo;
      logic       ee;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst;
   int          total = 0;
   int          bad = 0;
   vec_t        v[$];
   logic [63:0] q[$];
   noc_output_arbiter_if #(.NUM_IN(5), .FLIT_W(64)) bus();
   noc_output_arbiter #(.NUM_IN(5), .FLIT_W(64), .CREDITS(4)) dut (
      .clk_i(clk), .rst_i(rst), .bus_io(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] fl(int c, int i, logic [1:0] t);
      return {t, 54'(c), 8'(i)};
   endfunction
   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask
   task automatic sb();
      if (bus.valid_out === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb: valid_out with no flit expected, got %h", bus.flit_out);
         end else chk("sb flit", bus.flit_out, q.pop_front());
      end
   endtask
   task automatic drive(int c, logic [4:0] r, logic [9:0] t, logic cr, logic [4:0] p);
      bus.req = r;
      bus.credit_ret = cr;
      bus.pw = p;
      for (int i = 0; i < 5; i++) bus.flit_in[i*64 +: 64] = fl(c, i, t[2*i +: 2]);
   endtask
   task automatic add(logic [4:0] r, logic [9:0] t, logic cr, logic [4:0] eg, logic el,
                      logic [2:0] ec, logic ev, logic [2:0] eo, logic ee);
      v.push_back('{r, t, cr, eg, el, ec, ev, eo, ee});
   endtask
   initial begin
      logic [2:0] pw_win;
      // input 2: head, body, tail; then credits return and saturate
      add(5'b00100, 10'b00_00_11_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0);
      add(5'b00100, 10'b00_00_11_00_00, 1'b0, 5'b00100, 1'b1, 3'd4, 1'b0, 3'd2, 1'b0);
      add(5'b00100, 10'b00_00_01_00_00, 1'b0, 5'b00100, 1'b1, 3'd3, 1'b1, 3'd2, 1'b0);
      add(5'b00100, 10'b00_00_10_00_00, 1'b0, 5'b00100, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0);
      add(5'b00000, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b1, 3'd2, 1'b0);
      add(5'b00000, 10'b00_00_00_00_00, 1'b1, 5'b00000, 1'b0, 3'd1, 1'b0, 3'd2, 1'b0);
      add(5'b00000, 10'b00_00_00_00_00, 1'b1, 5'b00000, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0);
      add(5'b00000, 10'b00_00_00_00_00, 1'b1, 5'b00000, 1'b0, 3'd3, 1'b0, 3'd2, 1'b0);
      add(5'b00000, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 3'd2, 1'b0);
      add(5'b00000, 10'b00_00_00_00_00, 1'b1, 5'b00000, 1'b0, 3'd4, 1'b0, 3'd2, 1'b0);
      // inputs 0 and 3 single-flit packets, rr starts at 3
      add(5'b01001, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 3'd2, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b1, 5'b01000, 1'b1, 3'd4, 1'b0, 3'd3, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b1, 3'd3, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b1, 5'b00001, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b1, 3'd0, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b1, 5'b01000, 1'b1, 3'd4, 1'b0, 3'd3, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b1, 3'd3, 1'b1);
      add(5'b01001, 10'b00_00_00_00_00, 1'b1, 5'b00001, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1);
      add(5'b00000, 10'b00_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b1, 3'd0, 1'b1);
      // input 1 six-flit packet: credit stall, upstream stall, input 4 waits
      add(5'b10010, 10'b11_00_00_11_00, 1'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 3'd0, 1'b1);
      add(5'b10010, 10'b11_00_00_11_00, 1'b0, 5'b00010, 1'b1, 3'd4, 1'b0, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_01_00, 1'b0, 5'b00010, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_01_00, 1'b0, 5'b00010, 1'b1, 3'd2, 1'b1, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_01_00, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_01_00, 1'b0, 5'b00000, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_01_00, 1'b1, 5'b00000, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_01_00, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1);
      add(5'b10000, 10'b11_00_00_00_00, 1'b1, 5'b00000, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1);
      add(5'b10000, 10'b11_00_00_00_00, 1'b0, 5'b00000, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1);
      add(5'b10000, 10'b11_00_00_00_00, 1'b0, 5'b00000, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1);
      add(5'b10010, 10'b11_00_00_10_00, 1'b0, 5'b00010, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1);
      add(5'b10000, 10'b11_00_00_00_00, 1'b1, 5'b00000, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1);
      add(5'b10000, 10'b11_00_00_00_00, 1'b0, 5'b00000, 1'b0, 3'd1, 1'b0, 3'd1, 1'b1);
      add(5'b00000, 10'b11_00_00_00_00, 1'b0, 5'b00000, 1'b1, 3'd1, 1'b0, 3'd4, 1'b1);
      rst = 1'b1;
      drive(0, 5'b0, 10'b0, 1'b0, 5'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset locked", 64'(bus.locked), 64'(0));
      for (int c = 0; c < v.size(); c++) begin
         drive(c, v[c].req, v[c].typ, v[c].cr, 5'b0);
         for (int i = 0; i < 5; i++)
            if (v[c].eg[i]) q.push_back(fl(c, i, v[c].typ[2*i +: 2]));
         @(negedge clk);
         chk($sformatf("c%0d gnt", c), 64'(bus.gnt), 64'(v[c].eg));
         chk($sformatf("c%0d locked", c), 64'(bus.locked), 64'(v[c].el));
         chk($sformatf("c%0d credits", c), 64'(bus.credits), 64'(v[c].ec));
         chk($sformatf("c%0d valid_out", c), 64'(bus.valid_out), 64'(v[c].ev));
         chk($sformatf("c%0d owner", c), 64'(bus.owner), 64'(v[c].eo));
         chk($sformatf("c%0d credit_err", c), 64'(bus.credit_err), 64'(v[c].ee));
         sb();
         @(posedge clk);
         #1;
      end
      // async reset while locked to input 4 with one credit
      drive(34, 5'b10000, 10'b11_00_00_00_00, 1'b0, 5'b0);
      #1 chk("pre-reset gnt", 64'(bus.gnt), 64'(5'b10000));
      #1 rst = 1'b1;
      #1;
      chk("async locked", 64'(bus.locked), 64'(0));
      chk("async credits", 64'(bus.credits), 64'(4));
      chk("async gnt", 64'(bus.gnt), 64'(0));
      chk("async valid_out", 64'(bus.valid_out), 64'(0));
      chk("async credit_err", 64'(bus.credit_err), 64'(0));
      chk("async owner", 64'(bus.owner), 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(100, 5'b00001, 10'b00_00_00_00_11, 1'b0, 5'b0);
      @(posedge clk);
      @(negedge clk);
      chk("post-reset locked", 64'(bus.locked), 64'(1));
      chk("post-reset owner", 64'(bus.owner), 64'(0));
      chk("post-reset gnt", 64'(bus.gnt), 64'(5'b00001));
      chk("post-reset valid_out", 64'(bus.valid_out), 64'(0));
      sb();
      q.push_back(fl(100, 0, 2'b11));
      @(posedge clk);
      #1 drive(101, 5'b00001, 10'b00_00_00_00_10, 1'b0, 5'b0);
      @(negedge clk);
      chk("tail gnt", 64'(bus.gnt), 64'(5'b00001));
      chk("tail valid_out", 64'(bus.valid_out), 64'(1));
      sb();
      q.push_back(fl(101, 0, 2'b10));
      @(posedge clk);
      #1 drive(102, 5'b0, 10'b0, 1'b0, 5'b0);
      @(negedge clk);
      chk("release locked", 64'(bus.locked), 64'(0));
      chk("release valid_out", 64'(bus.valid_out), 64'(1));
      chk("release credits", 64'(bus.credits), 64'(2));
      sb();
      // heads on 0 and 3 with pw[3], rr back at 0
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      drive(103, 5'b01001, 10'b00_11_00_00_11, 1'b0, 5'b01000);
`ifdef ARB_PW_PRIORITY_EN
      pw_win = 3'd3;
`else
      pw_win = 3'd0;
`endif
      @(posedge clk);
      @(negedge clk);
      chk("pw owner", 64'(bus.owner), 64'(pw_win));
      chk("pw gnt", 64'(bus.gnt), 64'(5'b00001 << pw_win));
      chk("sb drained", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

- Shares one router output channel among the NUM_IN input ports of a NoC router.
- Each input port presents its buffered head flit and a route request for this output.
- The block picks one input by round-robin and holds the output for that input (wormhole lock) until the tail flit passes.
- It meters flits against downstream buffer credits and drives a registered flit onto the link. One instance sits behind each output port of the crossbar.

## Interface
Parameters:
- NUM_IN, 5, number of requesting input ports (max 8)
- FLIT_W, 64, flit width; type field in bits [FLIT_W-1:FLIT_W-2]
- CREDITS, 4, downstream buffer depth (1..7)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  reset, asynchronous and active-high
- req  input  NUM_IN  input i has a flit routed to this output
- pw  input  NUM_IN  priority request per input (used only with ARB_PW_PRIORITY_EN)
- flit_in  input  NUM_IN*FLIT_W  flit of input i at slice [i*FLIT_W +: FLIT_W]
- credit_ret  input  1  downstream freed one buffer slot
- gnt  output  NUM_IN  one-hot pop to input i; flit consumed this cycle
- flit_out  output  FLIT_W  registered output flit
- valid_out  output  1  flit_out valid (a push to downstream)
- credits  output  3  current credit count
- locked  output  1  state is LOCKED
- owner  output  3  index of locked input
- credit_err  output  1  sticky; credit_ret arrived with credits == CREDITS

## Operation
- Flit types: 2'b11 head, 2'b01 body, 2'b10 tail, 2'b00 single-flit packet (head and tail).
- State IDLE:
  - Eligible inputs: req[i]=1, type 11 or 00, and credits>0.
  - Winner: first eligible index at or after rr_ptr, wrapping modulo NUM_IN.
  - Next state is LOCKED with owner = winner.
  - No gnt is issued in IDLE.
  - Body or tail flits at a request in IDLE are never granted and never win.
- State LOCKED:
  - gnt[owner] = req[owner] && credits>0, combinational; all other gnt bits are 0.
  - On a granted flit of type 10 or 00: next state is IDLE and rr_ptr = (owner+1) mod NUM_IN.
  - Otherwise the block stays LOCKED, including while the owner's req is low (the packet is stalled upstream).
- Datapath: when any gnt bit is set, flit_out <= flit_in[owner] and valid_out <= 1; otherwise valid_out <= 0 and flit_out holds.
- Credits:
  - A grant alone decrements.
  - credit_ret alone increments.
  - Both together leave the count unchanged.
  - credit_ret at CREDITS saturates and sets credit_err.
  - A grant is never issued at 0 credits.
- Reset values:
  - state IDLE, owner 0, rr_ptr 0, credits CREDITS.
  - gnt 0, valid_out 0, flit_out 0, locked 0, credit_err 0.
- Reset mid-packet: the lock is dropped immediately. Any partially sent packet is abandoned; upstream and downstream recovery is out of scope.

## Timing
- Request with head flit at cycle 0 in IDLE: locked=1 at cycle 1; gnt at cycle 1 if credits>0; valid_out at cycle 2.
- Throughput while LOCKED with credits available: 1 flit/cycle.
- Packet switch cost: tail granted at cycle N, IDLE at N+1, next owner granted at N+2. This gives exactly one idle output cycle.
- Credit loop: a credit_ret at cycle k enables a grant at cycle k+1 when credits was 0.
- gnt depends combinationally on req and the registered state and credits only. There is no path from flit_in to gnt except the type decode of the owner's flit used for tail detection.

## Configuration
- ARB_PW_PRIORITY_EN defined:
  - In IDLE, if any eligible input has pw[i]=1, the winner is the first such input at or after rr_ptr.
  - Inputs without pw are considered only when no eligible pw input exists.
  - The lock, release and rr_ptr update are unchanged.
- ARB_PW_PRIORITY_EN undefined: pw is ignored and arbitration is pure round-robin.

## Test plan
- Single input: reset, then input 2 sends head, body, tail back-to-back with CREDITS=4 and no credit_ret.
  - gnt[2] at cycles 1,2,3; valid_out at cycles 2,3,4; credits 4→1.
  - locked falls at cycle 4; rr_ptr=3.
- Round-robin: inputs 0 and 3 both hold single-flit (00) packets continuously, rr_ptr=0.
  - Grant order is 0,3,0,3 with one bubble between packets.
- Credit stall: CREDITS=2, owner sends a 4-flit packet with no credit_ret.
  - Two flits pass, then gnt=0 and locked=1 hold.
  - credit_ret pulse at cycle k gives gnt at k+1.
- Lock hold and saturation:
  - Input 1 is locked, drops req for 3 cycles mid-packet while input 4 requests a head: input 4 is never granted until input 1's tail is granted.
  - credit_ret at credits=4: credits stays 4 and credit_err=1.
- Async reset mid-packet: assert reset between clock edges while LOCKED with credits=1.
  - Outputs go to reset values immediately: locked=0, credits=4, gnt=0.
  - The next head from input 0 is granted 1 cycle after reset release.
- ARB_PW_PRIORITY_EN:
  - rr_ptr=0, heads on inputs 0 and 3, pw[3]=1: input 3 wins.
  - Same stimulus without the macro: input 0 wins.
